// File: rtl/bc_stream_gen.sv
// bc_stream_gen: queued barcode stimulus generator.
// Station IDs are buffered in a small circular queue. Each ID is sent on BC
// as a pulse-width frame: a start cell, ID_W data cells (MSB first), an
// optional odd-parity cell, then GAP_CELLS idle-high cells.
// Optional feature macro: BC_PARITY_EN (adds the parity cell).
// GAP_CELLS is expected to be at least 1.
module bc_stream_gen #(
  parameter int ID_W      = 8,
  parameter int DEPTH     = 4,
  parameter int PER_W     = 22,
  parameter int GAP_CELLS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PER_W-1:0] period,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             BC,
  output logic             busy,
  output logic             frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (ID_W > 1) ? $clog2(ID_W) : 1;
  localparam int GW = (GAP_CELLS > 1) ? $clog2(GAP_CELLS) : 1;
`ifdef BC_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PAR,
    S_GAP
  } state_t;

  // ---------------- ID queue ----------------
  logic [ID_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push_ok;
  logic            pop;
  logic [ID_W-1:0] head;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign head    = mem[rd_ptr];

  // Queue storage write; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_id;
  end

  // Queue pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count    <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      overflow <= overflow | (push & full);
    end
  end

  // ---------------- frame FSM ----------------
  state_t           state, state_n;
  logic [PER_W-1:0] timer, timer_n;
  logic [PER_W-1:0] per_q, per_n;
  logic [PER_W-1:0] per_in;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic [ID_W-1:0]  shift, shift_n;
  logic             par_q, par_n;
  logic             busy_n;
  logic             bc_n;
  logic             done_n;
  logic             timer_last;
  logic [PER_W-1:0] half_n, quart_n;

  assign per_in     = (period < PER_W'(8)) ? PER_W'(8) : period;
  assign timer_last = (timer == per_q - PER_W'(1));

  // State and datapath registers; BC and frame_done come from next-state
  // values so the line changes on the same edge the cell boundary is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      per_q      <= PER_W'(8);
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shift      <= '0;
      par_q      <= 1'b0;
      busy       <= 1'b0;
      BC         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      per_q      <= per_n;
      bit_cnt    <= bit_n;
      gap_cnt    <= gap_n;
      shift      <= shift_n;
      par_q      <= par_n;
      busy       <= busy_n;
      BC         <= bc_n;
      frame_done <= done_n;
    end
  end

  // Next-state logic: cell sequencing, queue pop, period latch.
  always_comb begin
    state_n = state;
    timer_n = timer;
    per_n   = per_q;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    shift_n = shift;
    par_n   = par_q;
    busy_n  = busy;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (!empty || push_ok) state_n = S_LOAD;
      end
      S_LOAD: begin
        pop     = 1'b1;
        shift_n = head;
        par_n   = ~^head;
        per_n   = per_in;
        busy_n  = 1'b1;
        timer_n = '0;
        state_n = S_START;
      end
      S_START: begin
        if (timer_last) begin
          timer_n = '0;
          bit_n   = BW'(ID_W - 1);
          state_n = S_DATA;
        end else begin
          timer_n = timer + PER_W'(1);
        end
      end
      S_DATA: begin
        if (timer_last) begin
          timer_n = '0;
          shift_n = shift << 1;
          if (bit_cnt == '0) begin
            gap_n   = '0;
            state_n = PAR_EN ? S_PAR : S_GAP;
          end else begin
            bit_n = bit_cnt - BW'(1);
          end
        end else begin
          timer_n = timer + PER_W'(1);
        end
      end
      S_PAR: begin
        if (timer_last) begin
          timer_n = '0;
          gap_n   = '0;
          state_n = S_GAP;
        end else begin
          timer_n = timer + PER_W'(1);
        end
      end
      S_GAP: begin
        if (timer_last) begin
          timer_n = '0;
          if (gap_cnt == GW'(GAP_CELLS - 1)) begin
            state_n = empty ? S_IDLE : S_LOAD;
            busy_n  = !empty;
          end else begin
            gap_n = gap_cnt + GW'(1);
          end
        end else begin
          timer_n = timer + PER_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Line level and end-of-frame pulse derived from the upcoming cycle.
  always_comb begin
    half_n  = per_n >> 1;
    quart_n = per_n >> 2;
    bc_n    = 1'b1;
    case (state_n)
      S_START: bc_n = !(timer_n < half_n);
      S_DATA:  bc_n = !(timer_n < (shift_n[ID_W-1] ? quart_n : half_n + quart_n));
      S_PAR:   bc_n = !(timer_n < (par_n ? quart_n : half_n + quart_n));
      default: bc_n = 1'b1;
    endcase
    done_n = (state_n == S_GAP) && (timer_n == per_n - PER_W'(1)) &&
             (gap_n == GW'(GAP_CELLS - 1));
  end

endmodule

// File: tb/tb_bc_stream_gen.sv
// Testbench for bc_stream_gen: queue model plus frame scoreboard.
module tb_bc_stream_gen;
  localparam int ID_W  = 8;
  localparam int DEPTH = 4;
  localparam int PER_W = 22;
  localparam int GAPC  = 2;
`ifdef BC_PARITY_EN
  localparam int PARC = 1;
`else
  localparam int PARC = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [PER_W-1:0] period;
  logic             push;
  logic [ID_W-1:0]  push_id;
  logic             full, empty, overflow, BC, busy, frame_done;

  bc_stream_gen #(.ID_W(ID_W), .DEPTH(DEPTH), .PER_W(PER_W), .GAP_CELLS(GAPC)) dut (
    .clk(clk), .rst(rst), .period(period), .push(push), .push_id(push_id),
    .full(full), .empty(empty), .overflow(overflow), .BC(BC), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int p;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  int   mq[$];
  bit   m_ovf    = 1'b0;
  bit   d_in     = 1'b0;
  bit   d_prev   = 1'b1;
  int   exp_fall = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor: decode BC and compare frames ----------------
  bit m_in   = 1'b0;
  bit m_prev = 1'b1;
  int falls[$];
  int rises[$];

  function automatic int low_for(input int bitv, input int p);
    return bitv ? (p / 4) : (p / 2 + p / 4);
  endfunction

  task automatic check_frame();
    exp_t e;
    int   n, ones, bitv, expl;
    if (!m_in || sb.size() == 0) begin
      check("unexpected_frame_done", 1, 0);
      return;
    end
    e = sb.pop_front();
    n = 1 + ID_W + PARC;
    check("cell_count", falls.size(), n);
    check("rise_count", rises.size(), n);
    if (falls.size() == n && rises.size() == n) begin
      ones = 0;
      for (int b = 0; b < ID_W; b++) ones += (e.id >> b) & 1;
      for (int i = 0; i < n; i++) begin
        if (i == 0)          expl = e.p / 2;
        else if (i <= ID_W) begin
          bitv = (e.id >> (ID_W - i)) & 1;
          expl = low_for(bitv, e.p);
        end else             expl = low_for((ones % 2 == 0) ? 1 : 0, e.p);
        check($sformatf("low_cell%0d_id%0h", i, e.id), rises[i] - falls[i], expl);
        if (i < n - 1)
          check($sformatf("len_cell%0d_id%0h", i, e.id), falls[i+1] - falls[i], e.p);
      end
      check($sformatf("frame_len_id%0h", e.id), cyc - falls[0] + 1, (n + GAPC) * e.p);
    end
    m_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_in   = 1'b0;
      m_prev = 1'b1;
      falls.delete();
      rises.delete();
    end else begin
      if (m_prev && !BC) begin
        if (!m_in) begin
          m_in = 1'b1;
          falls.delete();
          rises.delete();
        end
        falls.push_back(cyc);
      end
      if (!m_prev && BC) rises.push_back(cyc);
      if (frame_done) check_frame();
      m_prev = BC;
    end
  end

  // ---------------- driver with queue model ----------------
  // One clock; afterwards account for the edge using the inputs held over it.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      mq.delete();
      sb.delete();
      m_ovf    = 1'b0;
      d_in     = 1'b0;
      d_prev   = 1'b1;
      exp_fall = -1;
    end else begin
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(int'(push_id));
        else m_ovf = 1'b1;
      end
      if (!d_in && d_prev && !BC) begin
        if (mq.size() == 0) check("start_with_empty_model", 1, 0);
        else begin
          e.id = mq.pop_front();
          e.p  = (period < 8) ? 8 : int'(period);
          sb.push_back(e);
        end
        check("busy_at_start", int'(busy), 1);
        if (exp_fall >= 0) begin
          check("b2b_start_cycle", cyc, exp_fall);
          exp_fall = -1;
        end
        d_in = 1'b1;
      end
      if (frame_done) begin
        d_in = 1'b0;
        if (mq.size() > 0) exp_fall = cyc + 2;
      end
      d_prev = BC;
      check("full", int'(full), int'(mq.size() == DEPTH));
      check("empty", int'(empty), int'(mq.size() == 0));
      check("overflow", int'(overflow), int'(m_ovf));
    end
  endtask

  task automatic do_push(input int id);
    push    = 1'b1;
    push_id = ID_W'(id);
    step();
    push    = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while ((mq.size() != 0 || d_in) && k < bound) begin
      step();
      k++;
    end
    if (k >= bound) check("drain_timeout", 1, 0);
    repeat (3) step();
  endtask

  task automatic wait_start(input int bound);
    int k = 0;
    while (!d_in && k < bound) begin
      step();
      k++;
    end
    if (k >= bound) check("start_timeout", 1, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    push    = 1'b0;
    push_id = '0;
    period  = PER_W'(16);
    step();
    step();
    rst = 1'b0;

    // Idle after reset.
    repeat (100) step();
    check("idle_bc", int'(BC), 1);
    check("idle_busy", int'(busy), 0);
    check("idle_empty", int'(empty), 1);
    check("idle_frame_done", int'(frame_done), 0);

    // Single ID from idle: latency then frame contents.
    period = PER_W'(16);
    do_push(8'hA5);
    check("lat_bc_n1", int'(BC), 1);
    step();
    check("lat_bc_n2", int'(BC), 0);
    wait_drain(2000);
    do_push(8'h07);
    wait_drain(2000);

    // Fill the queue while a frame runs, overflow on the fifth.
    do_push(8'h01);
    repeat (3) step();
    do_push(8'h02);
    do_push(8'h03);
    do_push(8'h04);
    do_push(8'h06);
    check("full_after_4", int'(full), 1);
    do_push(8'hFF);
    check("overflow_set", int'(overflow), 1);
    wait_drain(5000);

    // Clamped period, then mid-frame period change.
    period = PER_W'(4);
    do_push(8'h3C);
    wait_start(50);
    repeat (10) step();
    period = PER_W'(32);
    do_push(8'h5A);
    wait_drain(5000);

    // Reset in the middle of data bit 3 with another ID queued.
    period = PER_W'(16);
    do_push(8'h96);
    do_push(8'h11);
    wait_start(50);
    repeat (5 * 16 + 3) step();
    rst = 1'b1;
    step();
    check("rst_bc", int'(BC), 1);
    check("rst_empty", int'(empty), 1);
    check("rst_overflow", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    step();
    rst = 1'b0;
    repeat (300) step();
    check("post_rst_bc", int'(BC), 1);
    check("post_rst_empty", int'(empty), 1);

    // Randomized traffic with occasional period changes (including clamped).
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 499) == 0) period = PER_W'($urandom_range(0, 40));
      if ($urandom_range(0, 99) < 2) do_push(int'($urandom_range(0, 255)));
      else step();
    end
    wait_drain(12000);

    check("final_sb_empty", sb.size(), 0);
    check("final_pending_start", int'(exp_fall >= 0), 0);
    check("final_busy", int'(busy), 0);
    check("final_bc", int'(BC), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
